// File: rtl/celloutsig_misr_capture.sv
// Capture stage for the celloutsig out_data bus: folds accepted words into a MISR,
// counts words and toggles of one monitored bit, and holds the signature when a run ends.
module celloutsig_misr_capture #(
    parameter int                DATA_W  = 96,
    parameter int                SIG_W   = 32,
    parameter logic [SIG_W-1:0]  POLY    = 32'h04C11DB7,
    parameter logic [SIG_W-1:0]  SEED    = 32'hFFFFFFFF,
    parameter int                CNT_W   = 16,
    parameter int                TAP_BIT = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  run_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [SIG_W-1:0]  sig_o,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  tog_cnt,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   len_q;
    logic               tap_q;
    logic               first_q;
    logic               start_ok;
    logic               accept;
    logic               last_word;
    logic               tog_hit;
    logic [SIG_W-1:0]   fold;
    logic [SIG_W-1:0]   sig_step;

    assign in_ready = (state == RUN);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    // abort dominates both a start and an accept landing in the same cycle
    assign start_ok  = start & ~abort & (state != RUN);
    assign accept    = in_valid & in_ready & ~abort;
    assign last_word = accept & ((word_cnt + CNT_W'(1)) == len_q);
    assign tog_hit   = accept & ~first_q & (in_data[TAP_BIT] != tap_q) & (tog_cnt != '1);

    // NOTE: combinational blocks use blocking '=' and assign every output a default
    // before any branch, so no latch is inferred; clocked blocks use '<=' only.
    always_comb begin
        fold = '0;
        for (int i = 0; i < DATA_W / SIG_W; i++) begin
            fold = fold ^ in_data[i*SIG_W +: SIG_W];
        end
        sig_step = {sig_o[SIG_W-2:0], 1'b0} ^ (sig_o[SIG_W-1] ? POLY : '0) ^ fold;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_ok) state_nx = (run_len == '0) ? DONE : RUN;
            end
            RUN: begin
                if (abort)          state_nx = IDLE;
                else if (last_word) state_nx = DONE;
            end
            DONE: begin
                if (abort)         state_nx = IDLE;
                else if (start_ok) state_nx = (run_len == '0) ? DONE : RUN;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: every register here, including len_q and the tap/first flags, is reset so
    // an asynchronous reset mid-run leaves no partial run state behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sig_o    <= SEED;
            word_cnt <= '0;
            tog_cnt  <= '0;
            len_q    <= '0;
            tap_q    <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                sig_o    <= SEED;
                word_cnt <= '0;
                tog_cnt  <= '0;
                len_q    <= run_len;
                first_q  <= 1'b1;
            end else if (accept) begin
                sig_o    <= sig_step;
                word_cnt <= word_cnt + CNT_W'(1);
                if (tog_hit) tog_cnt <= tog_cnt + CNT_W'(1);
                tap_q    <= in_data[TAP_BIT];
                first_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_celloutsig_misr_capture.sv
// Bench for celloutsig_misr_capture: table-driven runs, hand-written corner sequences,
// and randomized runs scored against a word-list reference model.
module tb_celloutsig_misr_capture;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, in_valid;
    logic [15:0] run_len;
    logic [95:0] in_data;
    logic        in_ready, busy, done;
    logic [31:0] sig_o;
    logic [15:0] word_cnt, tog_cnt;

    logic        z_start, z_abort, z_valid;
    logic [15:0] z_run_len;
    logic [95:0] z_data;
    logic        z_ready, z_busy, z_done;
    logic [31:0] z_sig;
    logic [15:0] z_word_cnt, z_tog_cnt;

    always #5 clk = ~clk;

    celloutsig_misr_capture dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .run_len(run_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .sig_o(sig_o),
        .word_cnt(word_cnt), .tog_cnt(tog_cnt), .busy(busy), .done(done)
    );

    celloutsig_misr_capture #(.SEED(32'h0)) dut_z (
        .clk(clk), .rst_n(rst_n), .start(z_start), .abort(z_abort), .run_len(z_run_len),
        .in_valid(z_valid), .in_ready(z_ready), .in_data(z_data), .sig_o(z_sig),
        .word_cnt(z_word_cnt), .tog_cnt(z_tog_cnt), .busy(z_busy), .done(z_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the signature is the seed polynomial multiplied by x once per word,
    // reduced mod POLY, plus the XOR-fold of the word's three 32-bit slices.
    function automatic logic [31:0] misr_ref(input logic [31:0] s, input logic [95:0] w);
        logic [32:0] prod;
        logic [31:0] f;
        f    = w[31:0] ^ w[63:32] ^ w[95:64];
        prod = {s, 1'b0};
        if (prod[32]) prod[31:0] = prod[31:0] ^ POLY;
        return prod[31:0] ^ f;
    endfunction

    logic [31:0] m_sig;
    int          m_words, m_tog;
    logic        m_prev, m_first;

    task automatic model_start(input logic [31:0] seed);
        m_sig = seed; m_words = 0; m_tog = 0; m_prev = 1'b0; m_first = 1'b1;
    endtask

    task automatic model_accept(input logic [95:0] w);
        m_sig = misr_ref(m_sig, w);
        m_words++;
        if (!m_first && (w[32] != m_prev)) m_tog++;
        m_prev  = w[32];
        m_first = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".sig"},  sig_o,    m_sig);
        check({tag, ".words"}, word_cnt, m_words);
        check({tag, ".tog"},  tog_cnt,  m_tog);
    endtask

    function automatic logic [95:0] rand_word();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic do_start(input logic [15:0] len);
        run_len = len;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        model_start(SEED);
    endtask

    // Optional idle cycles with junk data and in_valid low, then one accepted word.
    task automatic feed(input logic [95:0] w, input bit gaps);
        for (int g = 0; g < 4; g++) begin
            if (!gaps || $urandom_range(0, 1) == 0) break;
            in_valid = 1'b0;
            in_data  = rand_word();
            tick();
            check_model("gap");
        end
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        model_accept(w);
    endtask

    typedef struct {
        logic [15:0]       len;
        logic [3:0][95:0]  w;
        logic [31:0]       exp_sig;
        logic [15:0]       exp_tog;
    } vec_t;

    vec_t vt[4];

    initial begin
        logic [31:0] s;
        logic [95:0] b32;
        b32 = 96'h1_0000_0000;

        vt[0] = '{len: 16'd1, w: '0, exp_sig: 32'hFB3EE249, exp_tog: 16'd0};
        vt[1] = '{len: 16'd1, w: {288'h0, 96'hFB3EE249}, exp_sig: 32'h0, exp_tog: 16'd0};
        vt[2] = '{len: 16'd2, w: '0, exp_sig: 32'hF2BCD925, exp_tog: 16'd0};
        s = SEED;
        s = misr_ref(s, 96'h0);
        s = misr_ref(s, b32);
        s = misr_ref(s, b32);
        s = misr_ref(s, 96'h0);
        vt[3] = '{len: 16'd4, w: {96'h0, b32, b32, 96'h0}, exp_sig: s, exp_tog: 16'd2};

        start = 0; abort = 0; in_valid = 0; run_len = 0; in_data = '0;
        z_start = 0; z_abort = 0; z_valid = 0; z_run_len = 0; z_data = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst.sig", sig_o, SEED);
        check("rst.words", word_cnt, 0);
        check("rst.tog", tog_cnt, 0);
        check("rst.ready_busy_done", {in_ready, busy, done}, 3'b000);
        tick();
        rst_n = 1'b1;
        tick();

        // Valid offered while idle must be ignored.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = rand_word();
            tick();
        end
        in_valid = 1'b0;
        check("idle_valid.sig", sig_o, SEED);
        check("idle_valid.words", word_cnt, 0);

        for (int i = 0; i < 4; i++) begin
            do_start(vt[i].len);
            for (int k = 0; k < int'(vt[i].len); k++) feed(vt[i].w[k], i == 3);
            check($sformatf("vec%0d.sig", i), sig_o, vt[i].exp_sig);
            check($sformatf("vec%0d.tog", i), tog_cnt, vt[i].exp_tog);
            check($sformatf("vec%0d.words", i), word_cnt, vt[i].len);
            check($sformatf("vec%0d.ready_busy_done", i), {in_ready, busy, done}, 3'b001);
        end

        // Outputs hold in DONE even with valid offered.
        in_valid = 1'b1; in_data = rand_word();
        tick(); tick();
        in_valid = 1'b0;
        check("done_hold.sig", sig_o, vt[3].exp_sig);
        check("done_hold.words", word_cnt, 4);

        // Zero-seed instance: bit 32 alone folds to 1.
        z_run_len = 16'd2; z_start = 1'b1;
        tick();
        z_start = 1'b0; z_valid = 1'b1; z_data = 96'h1_0000_0000;
        tick();
        check("zseed.sig1", z_sig, 32'h1);
        tick();
        z_valid = 1'b0;
        check("zseed.sig2", z_sig, 32'h3);
        check("zseed.tog", z_tog_cnt, 0);
        check("zseed.done", z_done, 1'b1);

        // Mid-run abort together with a valid word.
        do_start(16'd8);
        for (int k = 0; k < 3; k++) feed(rand_word(), 1'b1);
        abort = 1'b1; in_valid = 1'b1; in_data = rand_word();
        tick();
        abort = 1'b0; in_valid = 1'b0;
        check("abort.busy_done", {busy, done}, 2'b00);
        check_model("abort");
        do_start(16'd5);
        check("restart.sig", sig_o, SEED);
        check("restart.words", word_cnt, 0);
        check("restart.tog", tog_cnt, 0);
        check("restart.busy", busy, 1'b1);
        abort = 1'b1; tick(); abort = 1'b0;

        // Zero-length run, abort beating start, start ignored while running.
        do_start(16'd0);
        check("len0.done", done, 1'b1);
        check("len0.sig", sig_o, SEED);
        start = 1'b1; abort = 1'b1; run_len = 16'd3;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_vs_start.busy_done", {busy, done}, 2'b00);
        do_start(16'd2);
        run_len = 16'd5; start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_run.busy", busy, 1'b1);
        check_model("start_in_run");
        feed(rand_word(), 1'b0);
        feed(rand_word(), 1'b0);
        check("start_in_run.done", done, 1'b1);
        check_model("start_in_run.end");

        // Randomized runs against the model.
        for (int r = 0; r < 10; r++) begin
            int len;
            len = $urandom_range(1, 7);
            do_start(16'(len));
            for (int k = 0; k < len; k++) feed(rand_word(), 1'b1);
            check($sformatf("rand%0d.done", r), done, 1'b1);
            check_model($sformatf("rand%0d", r));
        end

        // Asynchronous reset between edges mid-run.
        do_start(16'd4);
        feed(rand_word(), 1'b0);
        feed(rand_word(), 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst.sig", sig_o, SEED);
        check("async_rst.words", word_cnt, 0);
        check("async_rst.tog", tog_cnt, 0);
        check("async_rst.ready_busy_done", {in_ready, busy, done}, 3'b000);
        tick();
        rst_n = 1'b1;
        tick();
        do_start(16'd1);
        feed(96'h0, 1'b0);
        check("rerun.sig", sig_o, 32'hFB3EE249);
        check("rerun.words", word_cnt, 1);
        check("rerun.done", done, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/celloutsig_misr_capture.md
Name: celloutsig_misr_capture

Overview:
- Downstream capture stage for the 96-bit out_data bus of a celloutsig logic cone.
- Accepts out_data words over a valid/ready handshake and folds each word into a 32-bit multiple-input signature register (MISR).
- Counts accepted words, and counts toggles of the single live output bit (bit 32) between consecutive words.
- After a programmed run length, presents a stable signature for comparison against the golden value.

Parameters:
DATA_W, 96, width of captured word; must be a multiple of SIG_W
SIG_W, 32, signature width
POLY, 32'h04C11DB7, MISR feedback polynomial
SEED, 32'hFFFFFFFF, signature value loaded on reset and on start
CNT_W, 16, width of word and toggle counters
TAP_BIT, 32, index of the bit monitored for toggles

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; begins a run (honoured in IDLE or DONE)
abort  input  1  pulse; ends a run immediately, returns to IDLE
run_len  input  CNT_W  words per run; sampled on start
in_valid  input  1  in_data valid
in_ready  output  1  stage can accept
in_data  input  DATA_W  out_data word from the logic cone
sig_o  output  SIG_W  current signature
word_cnt  output  CNT_W  words accepted this run
tog_cnt  output  CNT_W  TAP_BIT toggles between consecutive accepted words
busy  output  1  state==RUN
done  output  1  state==DONE

Behaviour:
- Reset (async assert, sync release), all applied immediately:
  - state=IDLE, sig_o=SEED, word_cnt=0, tog_cnt=0.
  - in_ready=0, busy=0, done=0.
  - Internal tap register and first-word flag cleared.
- States and transitions:
  - IDLE: start with run_len!=0 -> RUN. start with run_len==0 -> DONE directly; signature stays SEED.
  - RUN: accept fires on the word where word_cnt+1==len_q -> DONE. abort -> IDLE.
  - DONE: start -> RUN (rerun). abort -> IDLE. Outputs held otherwise.
- On every start that is honoured:
  - sig_o<=SEED, word_cnt<=0, tog_cnt<=0, len_q<=run_len, first flag set.
  - No word is accepted in the start cycle.
- Handshake:
  - in_ready=1 only in RUN, registered-state combinational. Accept = in_valid & in_ready.
  - in_data is sampled only on accept.
  - in_valid while not ready: no state change, and no requirement on the sender to hold the word.
- Fold: f = XOR of the DATA_W/SIG_W consecutive SIG_W-bit slices of in_data (default d[31:0]^d[63:32]^d[95:64]).
- MISR update on accept, taking effect the following cycle (latency 1):
  - sig_next = ({sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0)) ^ f.
- Counters on accept:
  - word_cnt increments by one.
  - tog_cnt increments when in_data[TAP_BIT] differs from the tap register and the first flag is clear.
  - The tap register then takes in_data[TAP_BIT], and the first flag clears.
- Saturation: word_cnt cannot exceed len_q. tog_cnt saturates at all-ones and does not wrap.
- Simultaneous events:
  - abort wins over start and over accept in the same cycle; the accept is dropped and the counters are not updated.
  - start in RUN is ignored.
- Outputs in DONE and IDLE hold their last values until the next start or reset.
  - After abort, sig_o, word_cnt and tog_cnt retain their partial values.
- Reset asserted mid-run: immediate return to the reset values. The partial signature is lost.

Test Plan:
1. Reset, then start with run_len=1; one word in_data=0 -> one cycle later sig_o=32'hFB3EE249, word_cnt=1, done=1, in_ready=0.
2. SEED overridden to 0, run_len=2; two words with only bit 32 set -> sig_o=1 after the first word, 3 after the second; tog_cnt=0.
3. run_len=4; words with bit32 = 0,1,1,0; in_valid toggled randomly -> tog_cnt=2 and word_cnt=4. Non-accepted cycles must not change any state.
4. Mid-run abort:
   - run_len=8: after 3 words assert abort together with in_valid -> state IDLE, word_cnt=3, the 4th word is not folded.
   - Then start -> sig_o=SEED, counters 0.
5. start with run_len=0 -> DONE next cycle, sig_o=SEED. start asserted while RUN -> ignored, len_q unchanged.
6. Assert rst_n low asynchronously between clock edges mid-run:
   - outputs reach their reset values before the next edge;
   - deassert and rerun scenario 1 to confirm the same signature.
